// File: rtl/snitch_tcdm_bank_amo.sv
// Per-bank TCDM stage: passes loads/stores to a single-port SRAM and executes
// atomic memory operations as a two-cycle read-modify-write sequence.
module snitch_tcdm_bank_amo #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [3:0]           q_amo_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [StrbWidth-1:0] q_strb_i,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 p_valid_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [StrbWidth-1:0] sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_SWAP = 4'd1,
    AMO_ADD  = 4'd2,
    AMO_AND  = 4'd3,
    AMO_OR   = 4'd4,
    AMO_XOR  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MAXU = 4'd7,
    AMO_MIN  = 4'd8,
    AMO_MINU = 4'd9
  } amo_op_e;

  typedef enum logic {
    IDLE,
    AMO_WB
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   amo_addr_q;
  logic [3:0]             amo_op_q;
  logic [DataWidth-1:0]   amo_operand_q;
  logic [StrbWidth-1:0]   amo_strb_q;
  logic                   is_amo;
  logic [DataWidth-1:0]   amo_result;

  // Opcodes 10-15 are not atomics; such requests behave as plain loads/stores.
  assign is_amo = (q_amo_i >= AMO_SWAP) && (q_amo_i <= AMO_MINU);

  // The old value arrives on sram_rdata_i in the write-back cycle.
  always_comb begin
    amo_result = amo_operand_q;
    case (amo_op_q)
      AMO_SWAP: amo_result = amo_operand_q;
      AMO_ADD:  amo_result = sram_rdata_i + amo_operand_q;
      AMO_AND:  amo_result = sram_rdata_i & amo_operand_q;
      AMO_OR:   amo_result = sram_rdata_i | amo_operand_q;
      AMO_XOR:  amo_result = sram_rdata_i ^ amo_operand_q;
      AMO_MAX:  amo_result = ($signed(sram_rdata_i) > $signed(amo_operand_q)) ? sram_rdata_i : amo_operand_q;
      AMO_MAXU: amo_result = (sram_rdata_i > amo_operand_q) ? sram_rdata_i : amo_operand_q;
      AMO_MIN:  amo_result = ($signed(sram_rdata_i) < $signed(amo_operand_q)) ? sram_rdata_i : amo_operand_q;
      AMO_MINU: amo_result = (sram_rdata_i < amo_operand_q) ? sram_rdata_i : amo_operand_q;
      default:  amo_result = amo_operand_q;
    endcase
  end

  // NOTE: every output gets a default before the state override so no latch is inferred.
  always_comb begin
    q_ready_o    = 1'b1;
    sram_req_o   = q_valid_i;
    sram_we_o    = q_write_i & ~is_amo;
    sram_addr_o  = q_addr_i;
    sram_wdata_o = q_data_i;
    sram_be_o    = q_strb_i;
    if (state_q == AMO_WB) begin
      q_ready_o    = 1'b0;
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = amo_addr_q;
      sram_wdata_o = amo_result;
      sram_be_o    = amo_strb_q;
    end
  end

  assign p_data_o = sram_rdata_i;

  // NOTE: sequential state uses non-blocking assignments only; the AMO latches
  // are small registers, not a memory, so resetting them costs nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      p_valid_o     <= 1'b0;
      amo_addr_q    <= '0;
      amo_op_q      <= '0;
      amo_operand_q <= '0;
      amo_strb_q    <= '0;
    end else begin
      p_valid_o <= q_valid_i & q_ready_o;
      case (state_q)
        IDLE: begin
          if (q_valid_i && is_amo) begin
            amo_addr_q    <= q_addr_i;
            amo_op_q      <= q_amo_i;
            amo_operand_q <= q_data_i;
            amo_strb_q    <= q_strb_i;
            state_q       <= AMO_WB;
          end
        end
        AMO_WB:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snitch_tcdm_bank_amo.sv
// Bench for snitch_tcdm_bank_amo: directed vector table, hand-written corner
// sequences and a random phase against a transaction-level memory model.
module tb_snitch_tcdm_bank_amo;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          q_valid_i;
  logic          q_ready_o;
  logic [AW-1:0] q_addr_i;
  logic          q_write_i;
  logic [3:0]    q_amo_i;
  logic [DW-1:0] q_data_i;
  logic [SW-1:0] q_strb_i;
  logic [DW-1:0] p_data_o;
  logic          p_valid_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [SW-1:0] sram_be_o;
  logic [DW-1:0] sram_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  snitch_tcdm_bank_amo #(.AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
    .q_write_i(q_write_i), .q_amo_i(q_amo_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
    .p_data_o(p_data_o), .p_valid_o(p_valid_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port SRAM macro: byte-enabled write, read data one cycle after the strobe.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < SW; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  typedef struct {
    logic          v;
    logic          w;
    logic [3:0]    amo;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          exp_ready;
    logic          exp_pv;
    logic          chk_pd;
    logic [DW-1:0] exp_pd;
    logic          chk_wb;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic          rdy;
    logic          req;
    logic          we;
    logic [AW-1:0] sa;
    logic [DW-1:0] wd;
    logic [SW-1:0] be;
    logic          pv;
    logic [DW-1:0] pd;
  } obs_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: applies a request, samples the request-cycle outputs,
  // then samples the response just after the next rising edge.
  task automatic drive(input logic v, input logic w, input logic [3:0] amo, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [SW-1:0] strb, output obs_t o);
    q_valid_i = v; q_write_i = w; q_amo_i = amo; q_addr_i = addr; q_data_i = data; q_strb_i = strb;
    #1;
    o.rdy = q_ready_o; o.req = sram_req_o; o.we = sram_we_o;
    o.sa = sram_addr_o; o.wd = sram_wdata_o; o.be = sram_be_o;
    @(posedge clk_i);
    #1;
    o.pv = p_valid_o; o.pd = p_data_o;
  endtask

  function automatic vec_t mk(logic v, logic w, logic [3:0] amo, logic [AW-1:0] addr, logic [DW-1:0] data,
                              logic rdy, logic pv, logic chk_pd, logic [DW-1:0] pd,
                              logic chk_wb, logic [AW-1:0] waddr, logic [DW-1:0] wdata);
    vec_t t;
    t.v = v; t.w = w; t.amo = amo; t.addr = addr; t.data = data; t.strb = 4'hF;
    t.exp_ready = rdy; t.exp_pv = pv; t.chk_pd = chk_pd; t.exp_pd = pd;
    t.chk_wb = chk_wb; t.exp_waddr = waddr; t.exp_wdata = wdata;
    return t;
  endfunction

  // Reference semantics of the atomics, straight from the opcode table.
  function automatic logic [DW-1:0] ref_op(int op, logic [DW-1:0] old, logic [DW-1:0] opd);
    longint so = $signed(old);
    longint sd = $signed(opd);
    longint unsigned uo = old;
    longint unsigned ud = opd;
    case (op)
      1: return opd;
      2: return DW'(uo + ud);
      3: return old & opd;
      4: return old | opd;
      5: return old ^ opd;
      6: return (so >= sd) ? old : opd;
      7: return (uo >= ud) ? old : opd;
      8: return (so <= sd) ? old : opd;
      9: return (uo <= ud) ? old : opd;
      default: return old;
    endcase
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [SW-1:0] strb);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  vec_t tbl[$];
  obs_t o;
  logic [DW-1:0] ref_mem [8];
  logic model_busy;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sram_rdata_i = '0;
    rst_ni = 1'b0;
    q_valid_i = 1'b0; q_write_i = 1'b0; q_amo_i = '0; q_addr_i = '0; q_data_i = '0; q_strb_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_p_valid", {31'd0, p_valid_o}, 32'd0);
    check("reset_ready", {31'd0, q_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // ---- directed table ----
    tbl.push_back(mk(1, 1, 0, 10'h05, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 10'h05, 32'h0,        1, 1, 1, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 10'h10, 32'h7,        1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2, 10'h10, 32'h3,        1, 1, 1, 32'h7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10'h00, 32'h0,        0, 0, 0, 0, 1, 10'h10, 32'hA));
    tbl.push_back(mk(1, 0, 0, 10'h10, 32'h0,        1, 1, 1, 32'hA, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 10'h11, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6, 10'h11, 32'h1,        1, 1, 1, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10'h00, 32'h0,        0, 0, 0, 0, 1, 10'h11, 32'h1));
    tbl.push_back(mk(1, 1, 0, 10'h11, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 7, 10'h11, 32'h1,        1, 1, 1, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10'h00, 32'h0,        0, 0, 0, 0, 1, 10'h11, 32'hFFFFFFFF));
    tbl.push_back(mk(1, 0, 2, 10'h11, 32'h1,        1, 1, 1, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10'h00, 32'h0,        0, 0, 0, 0, 1, 10'h11, 32'h0));
    tbl.push_back(mk(1, 0, 0, 10'h11, 32'h0,        1, 1, 1, 32'h0, 0, 0, 0));
    // Back-to-back swaps; the second is held while the bank is busy.
    tbl.push_back(mk(1, 0, 1, 10'h20, 32'hAAAA5555, 1, 1, 1, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 10'h21, 32'h1234ABCD, 0, 0, 0, 0, 1, 10'h20, 32'hAAAA5555));
    tbl.push_back(mk(1, 0, 1, 10'h21, 32'h1234ABCD, 1, 1, 1, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10'h00, 32'h0,        0, 0, 0, 0, 1, 10'h21, 32'h1234ABCD));
    tbl.push_back(mk(1, 0, 0, 10'h20, 32'h0,        1, 1, 1, 32'hAAAA5555, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 10'h21, 32'h0,        1, 1, 1, 32'h1234ABCD, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10'h00, 32'h0,        1, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].amo, tbl[i].addr, tbl[i].data, tbl[i].strb, o);
      check($sformatf("vec%0d_ready", i), {31'd0, o.rdy}, {31'd0, tbl[i].exp_ready});
      check($sformatf("vec%0d_p_valid", i), {31'd0, o.pv}, {31'd0, tbl[i].exp_pv});
      if (tbl[i].chk_pd) check($sformatf("vec%0d_p_data", i), o.pd, tbl[i].exp_pd);
      if (tbl[i].chk_wb) begin
        check($sformatf("vec%0d_wb_req_we", i), {30'd0, o.req, o.we}, 32'd3);
        check($sformatf("vec%0d_wb_addr", i), {22'd0, o.sa}, {22'd0, tbl[i].exp_waddr});
        check($sformatf("vec%0d_wb_data", i), o.wd, tbl[i].exp_wdata);
        check($sformatf("vec%0d_wb_be", i), {28'd0, o.be}, 32'hF);
      end
    end

    // ---- zero-strobe store: write still issued, response still produced ----
    drive(1, 1, 0, 10'h05, 32'h11111111, 4'h0, o);
    check("strb0_req_we", {30'd0, o.req, o.we}, 32'd3);
    check("strb0_be", {28'd0, o.be}, 32'd0);
    check("strb0_p_valid", {31'd0, o.pv}, 32'd1);
    drive(1, 0, 0, 10'h05, 32'h0, 4'hF, o);
    check("strb0_unchanged", o.pd, 32'hDEADBEEF);

    // ---- load stream over addresses 0-7 ----
    for (int i = 0; i < 8; i++) drive(1, 1, 0, AW'(i), 32'h100 + i, 4'hF, o);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, AW'(i), 32'h0, 4'hF, o);
      check($sformatf("stream%0d_ready", i), {31'd0, o.rdy}, 32'd1);
      check($sformatf("stream%0d_p_valid", i), {31'd0, o.pv}, 32'd1);
      check($sformatf("stream%0d_p_data", i), o.pd, 32'h100 + i);
    end
    drive(0, 0, 0, 10'h0, 32'h0, 4'h0, o);
    check("stream_end_p_valid", {31'd0, o.pv}, 32'd0);

    // ---- random traffic over 0x40-0x47 against a transaction-level model ----
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    model_busy = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic v, w;
      logic [3:0] amo;
      logic [2:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic acc, op_amo;
      int kind;
      v = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 2);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'h80000000 | (d & 32'hF);
      s = 4'($urandom_range(0, 15));
      w = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      amo = (kind == 2) ? 4'($urandom_range(1, 9)) : 4'd0;
      drive(v, w, amo, 10'h40 + AW'(a), d, s, o);
      acc = v & ~model_busy;
      op_amo = (amo != 0);
      check("rand_ready", {31'd0, o.rdy}, {31'd0, ~model_busy});
      check("rand_p_valid", {31'd0, o.pv}, {31'd0, acc});
      if (acc && (op_amo || !w)) check($sformatf("rand_p_data_a%0d", a), o.pd, ref_mem[a]);
      if (acc && op_amo) ref_mem[a] = merge(ref_mem[a], ref_op(amo, ref_mem[a], d), s);
      else if (acc && w) ref_mem[a] = merge(ref_mem[a], d, s);
      model_busy = acc & op_amo;
    end
    drive(0, 0, 0, 10'h0, 32'h0, 4'h0, o);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 10'h40 + AW'(i), 32'h0, 4'hF, o);
      check($sformatf("rand_final_a%0d", i), o.pd, ref_mem[i]);
    end

    // ---- reset during AMO write-back ----
    drive(1, 1, 0, 10'h30, 32'h12345678, 4'hF, o);
    drive(1, 0, 2, 10'h30, 32'h1, 4'hF, o);
    check("rst_amo_old", o.pd, 32'h12345678);
    q_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_async_p_valid", {31'd0, p_valid_o}, 32'd0);
    check("rst_no_sram_req", {31'd0, sram_req_o}, 32'd0);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    #1;
    check("rst_release_ready", {31'd0, q_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    drive(1, 0, 0, 10'h30, 32'h0, 4'hF, o);
    check("rst_load_ready", {31'd0, o.rdy}, 32'd1);
    check("rst_load_data", o.pd, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
